mem_ctrl: RTL and testbench

// - Arbitrates the IF-stage fetch port and MEM-stage load/store port onto one byte-wide synchronous RAM.
// - Sequences each 32-bit access as 4 byte beats, little-endian; assembles read words and applies the store byte mask.
// - Drives the pipeline stall lines until the owning stage's transfer completes.

---
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Pipeline-side handshake bundle for mem_ctrl.
// slave = controller view, master = pipeline view.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_B = 4
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [8*WORD_B-1:0] if_data;
  logic              if_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_B-1:0] mem_mask;
  logic [8*WORD_B-1:0] mem_wdata;
  logic [8*WORD_B-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr,
    input  mem_read, mem_write,
    input  mem_addr, mem_mask, mem_wdata,
    output if_data, if_ready,
    output mem_rdata, mem_ready,
    output stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr,
    output mem_read, mem_write,
    output mem_addr, mem_mask, mem_wdata,
    input  if_data, if_ready,
    input  mem_rdata, mem_ready,
    input  stall_if, stall_mem
  );
endinterface

// File: rtl/mem_ctrl.sv
// Fetch/load-store arbiter onto a byte-wide sync RAM.
// MEM_CTRL_RR_EN selects round-robin grant instead of MEM-first.
module mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_B = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  mem_ctrl_if.slave         bus,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  localparam int DW = 8 * WORD_B;
  localparam int CW = $clog2(WORD_B);
  localparam logic [CW-1:0] LAST = CW'(WORD_B - 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    TAIL
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              gnt_mem;
  logic              st_op;
  logic [ADDR_W-1:0] base;
  logic [WORD_B-1:0] mask;
  logic [DW-1:0]     wdata;
  logic [DW-9:0]     rbuf;

  logic              pick_mem;
  logic              nb_st;
  logic [ADDR_W-1:0] nb_addr;
  logic [ADDR_W-1:0] nb_base;
  logic [CW-1:0]     nxt;
  logic [CW-1:0]     prv;

`ifdef MEM_CTRL_RR_EN
  logic last_mem;
`endif

  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = (bus.mem_read | bus.mem_write)
                       & ~bus.mem_ready;

  assign nxt = cnt + CW'(1);
  assign prv = cnt - CW'(1);

  // Stall lines double as "pending": a port on its ready
  // cycle is not re-granted for the request it just finished.
  always_comb begin
    pick_mem = bus.stall_mem;
`ifdef MEM_CTRL_RR_EN
    if (bus.stall_mem && bus.stall_if)
      pick_mem = ~last_mem;
`endif
    nb_addr = pick_mem ? bus.mem_addr : bus.if_addr;
    nb_base = nb_addr & ~ADDR_W'(WORD_B - 1);
    nb_st   = pick_mem & bus.mem_write;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      cnt           <= '0;
      gnt_mem       <= 1'b0;
      st_op         <= 1'b0;
      base          <= '0;
      mask          <= '0;
      wdata         <= '0;
      rbuf          <= '0;
      ram_en        <= 1'b0;
      ram_wr        <= 1'b0;
      ram_addr      <= '0;
      ram_dout      <= '0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      bus.if_data   <= '0;
      bus.mem_rdata <= '0;
`ifdef MEM_CTRL_RR_EN
      last_mem      <= 1'b0;
`endif
    end else begin
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.stall_if || bus.stall_mem) begin
            state    <= XFER;
            cnt      <= '0;
            gnt_mem  <= pick_mem;
            st_op    <= nb_st;
            base     <= nb_base;
            mask     <= bus.mem_mask;
            wdata    <= bus.mem_wdata;
            ram_en   <= 1'b1;
            ram_addr <= nb_base;
            ram_wr   <= nb_st & bus.mem_mask[0];
            ram_dout <= bus.mem_wdata[7:0];
`ifdef MEM_CTRL_RR_EN
            last_mem <= pick_mem;
`endif
          end
        end
        XFER: begin
          if (!st_op && cnt != '0)
            rbuf[8*prv +: 8] <= ram_din;
          if (cnt == LAST) begin
            ram_en <= 1'b0;
            ram_wr <= 1'b0;
            if (st_op) begin
              state         <= IDLE;
              bus.mem_ready <= 1'b1;
            end else begin
              state <= TAIL;
            end
          end else begin
            cnt      <= nxt;
            ram_addr <= base + ADDR_W'(nxt);
            ram_wr   <= st_op & mask[nxt];
            ram_dout <= wdata[8*nxt +: 8];
          end
        end
        TAIL: begin
          state <= IDLE;
          if (gnt_mem) begin
            bus.mem_rdata <= {ram_din, rbuf};
            bus.mem_ready <= 1'b1;
          end else begin
            bus.if_data  <= {ram_din, rbuf};
            bus.if_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model.
// Expected values are hand-derived per scenario.
module tb_mem_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        ram_en;
  logic        ram_wr;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  int total = 0;
  int bad = 0;

  logic [7:0]  ram [logic [31:0]];
  logic [31:0] beat_a[$];
  logic [31:0] wr_a[$];
  logic [7:0]  wr_d[$];

  always #5 CLK = ~CLK;

  mem_ctrl_if #(.ADDR_W(32), .WORD_B(4)) bus();

  mem_ctrl #(.ADDR_W(32), .WORD_B(4)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_wr   (ram_wr),
    .ram_addr (ram_addr),
    .ram_dout (ram_dout),
    .ram_din  (ram_din)
  );

  initial begin
    forever begin
      @(posedge CLK);
      if (ram_en) begin
        beat_a.push_back(ram_addr);
        if (ram_wr) begin
          ram[ram_addr] = ram_dout;
          wr_a.push_back(ram_addr);
          wr_d.push_back(ram_dout);
        end
        ram_din <= ram.exists(ram_addr) ? ram[ram_addr] : 8'h00;
      end
    end
  end

  task automatic clr_bus();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_mask  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic clr_log();
    beat_a.delete();
    wr_a.delete();
    wr_d.delete();
  endtask

  task automatic put4(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++)
      ram[a + 32'(k)] = w[8*k +: 8];
  endtask

  // Returns posedges until the port's ready is seen at a negedge, -1 on timeout.
  task automatic wait_rdy(input bit on_mem, output int n);
    n = 0;
    forever begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (on_mem ? bus.mem_ready : bus.if_ready) return;
      if (n >= 20) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    clr_bus();
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if ({ram_en, ram_wr, bus.if_ready, bus.mem_ready} !== 4'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=0000",
               {ram_en, ram_wr, bus.if_ready, bus.mem_ready});
    end
    total++;
    if (ram_addr !== 32'h0 || ram_dout !== 8'h0) begin
      bad++;
      $display("FAIL reset_ram got addr=%h dout=%h want 0",
               ram_addr, ram_dout);
    end
    total++;
    if (bus.if_data !== 32'h0 || bus.mem_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data got if=%h mem=%h want 0",
               bus.if_data, bus.mem_rdata);
    end
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_fetch();
    int n;
    put4(32'h100, 32'h0000_0513);
    clr_log();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    #1;
    total++;
    if (bus.stall_if !== 1'b1) begin
      bad++;
      $display("FAIL fetch_stall got=%b want=1", bus.stall_if);
    end
    wait_rdy(1'b0, n);
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL fetch_latency got=%0d want=6", n);
    end
    total++;
    if (bus.if_data !== 32'h0000_0513) begin
      bad++;
      $display("FAIL fetch_data got=%h want=00000513", bus.if_data);
    end
    total++;
    if (beat_a.size() !== 4 || wr_a.size() !== 0) begin
      bad++;
      $display("FAIL fetch_beats got beats=%0d writes=%0d want 4/0",
               beat_a.size(), wr_a.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (beat_a[k] !== 32'h100 + 32'(k)) begin
          bad++;
          $display("FAIL fetch_addr%0d got=%h want=%h",
                   k, beat_a[k], 32'h100 + 32'(k));
        end
      end
    end
    bus.if_req = 1'b0;
    @(negedge CLK);
    total++;
    if (bus.if_ready !== 1'b0 || bus.if_data !== 32'h0000_0513) begin
      bad++;
      $display("FAIL fetch_hold got rdy=%b data=%h want 0/00000513",
               bus.if_ready, bus.if_data);
    end
  endtask

  task automatic test_store_mask();
    int n;
    put4(32'h200, 32'h4433_2211);
    clr_log();
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h200;
    bus.mem_mask  = 4'b0110;
    bus.mem_wdata = 32'hAABB_CCDD;
    wait_rdy(1'b1, n);
    total++;
    if (n !== 5) begin
      bad++;
      $display("FAIL store_latency got=%0d want=5", n);
    end
    total++;
    if (beat_a.size() !== 4 || wr_a.size() !== 2) begin
      bad++;
      $display("FAIL store_count got beats=%0d writes=%0d want 4/2",
               beat_a.size(), wr_a.size());
    end else begin
      total++;
      if (wr_a[0] !== 32'h201 || wr_d[0] !== 8'hCC ||
          wr_a[1] !== 32'h202 || wr_d[1] !== 8'hBB) begin
        bad++;
        $display("FAIL store_bytes got %h=%h %h=%h want 201=cc 202=bb",
                 wr_a[0], wr_d[0], wr_a[1], wr_d[1]);
      end
    end
    total++;
    if (ram[32'h200] !== 8'h11 || ram[32'h203] !== 8'h44) begin
      bad++;
      $display("FAIL store_untouched got %h %h want 11 44",
               ram[32'h200], ram[32'h203]);
    end
    clr_bus();
    @(negedge CLK);
  endtask

  task automatic test_priority();
    int  n;
    bit  first_mem;
`ifdef MEM_CTRL_RR_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    put4(32'h300, 32'h0403_0201);
    put4(32'h400, 32'h0D0C_0B0A);
    clr_log();
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h400;
    bus.mem_read = 1'b1;
    bus.mem_addr = 32'h300;
    wait_rdy(first_mem, n);
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL prio_first_latency got=%0d want=6", n);
    end
    total++;
    if ((first_mem ? bus.stall_if : bus.stall_mem) !== 1'b1) begin
      bad++;
      $display("FAIL prio_other_stall got=0 want=1");
    end
    if (first_mem) bus.mem_read = 1'b0;
    else           bus.if_req = 1'b0;
    wait_rdy(!first_mem, n);
    total++;
    if (n !== 6) begin
      bad++;
      $display("FAIL prio_second_latency got=%0d want=6", n);
    end
    total++;
    if (bus.mem_rdata !== 32'h0403_0201 ||
        bus.if_data !== 32'h0D0C_0B0A) begin
      bad++;
      $display("FAIL prio_data got mem=%h if=%h want 04030201/0d0c0b0a",
               bus.mem_rdata, bus.if_data);
    end
    total++;
    if (beat_a.size() !== 8) begin
      bad++;
      $display("FAIL prio_beats got=%0d want=8", beat_a.size());
    end else if (beat_a[0] !== (first_mem ? 32'h300 : 32'h400) ||
                 beat_a[4] !== (first_mem ? 32'h400 : 32'h300)) begin
      bad++;
      $display("FAIL prio_order got %h,%h", beat_a[0], beat_a[4]);
    end
    clr_bus();
    @(negedge CLK);
  endtask

  task automatic test_wrap();
    int n;
    put4(32'hFFFF_FFFC, 32'h1234_5678);
    clr_log();
    bus.mem_read = 1'b1;
    bus.mem_addr = 32'hFFFF_FFFE;
    bus.mem_mask = 4'b0000;
    wait_rdy(1'b1, n);
    total++;
    if (n !== 6 || bus.mem_rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL wrap_load got n=%0d data=%h want 6/12345678",
               n, bus.mem_rdata);
    end
    total++;
    if (beat_a.size() !== 4) begin
      bad++;
      $display("FAIL wrap_beats got=%0d want=4", beat_a.size());
    end else if (beat_a[0] !== 32'hFFFF_FFFC ||
                 beat_a[3] !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_addr got %h..%h want fffffffc..ffffffff",
               beat_a[0], beat_a[3]);
    end
    clr_bus();
    @(negedge CLK);
  endtask

  task automatic test_mask0();
    int n;
    clr_log();
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h500;
    bus.mem_mask  = 4'b0000;
    bus.mem_wdata = 32'hFFFF_FFFF;
    wait_rdy(1'b1, n);
    total++;
    if (n !== 5 || beat_a.size() !== 4 || wr_a.size() !== 0) begin
      bad++;
      $display("FAIL mask0 got n=%0d beats=%0d writes=%0d want 5/4/0",
               n, beat_a.size(), wr_a.size());
    end
    clr_bus();
    @(negedge CLK);
  endtask

  task automatic test_drop();
    int n;
    clr_log();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h999;
    wait_rdy(1'b0, n);
    total++;
    if (n !== 4 || bus.if_data !== 32'h0000_0513) begin
      bad++;
      $display("FAIL drop got n=%0d data=%h want 4/00000513",
               n, bus.if_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_reset_mid();
    put4(32'h600, 32'h0);
    clr_log();
    bus.mem_write = 1'b1;
    bus.mem_addr  = 32'h600;
    bus.mem_mask  = 4'b1111;
    bus.mem_wdata = 32'h4433_2211;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    total++;
    if ({ram_en, ram_wr, bus.mem_ready} !== 3'b0 ||
        ram_addr !== 32'h0) begin
      bad++;
      $display("FAIL rstmid_out got en=%b wr=%b rdy=%b addr=%h want 0",
               ram_en, ram_wr, bus.mem_ready, ram_addr);
    end
    repeat (3) @(negedge CLK);
    total++;
    if (bus.mem_ready !== 1'b0 || wr_a.size() !== 2) begin
      bad++;
      $display("FAIL rstmid_writes got rdy=%b writes=%0d want 0/2",
               bus.mem_ready, wr_a.size());
    end
    total++;
    if (ram[32'h600] !== 8'h11 || ram[32'h601] !== 8'h22 ||
        ram[32'h602] !== 8'h00 || ram[32'h603] !== 8'h00) begin
      bad++;
      $display("FAIL rstmid_ram got %h %h %h %h want 11 22 00 00",
               ram[32'h600], ram[32'h601], ram[32'h602], ram[32'h603]);
    end
    clr_bus();
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_mask();
    test_priority();
    test_wrap();
    test_mask0();
    test_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
